// File: rtl/pc_unit.sv
// pc_unit: fetch-address register for the IF stage of the pipelined MIPS datapath.
// Picks the next PC from branch (EX), jump (ID) or sequential targets and applies
// stall, halt and debug single-step control. It also reports the run state and a
// saturating count of PC updates.
//
// Ports:
//   i_clk, i_reset       clock (rising edge) and asynchronous active-high reset
//   i_enable, i_mode     debug run enable; mode 0 = continuous, 1 = single-step
//   i_step               step request level, edge-detected in step mode
//   i_stall, i_halt      hazard-unit stall; HALT decoded in ID
//   i_jump*, i_branch*   redirect requests and their targets
//   o_pc, o_pc_plus      registered fetch address and o_pc + INC
//   o_fetch              high for the cycle after each PC update
//   o_halted             high while in the HALTED state
//   o_fetch_count        saturating count of PC updates
module pc_unit #(
   parameter int               NBITS        = 32,
   parameter int               INC          = 4,
   parameter logic [NBITS-1:0] RESET_VECTOR = '0,
   parameter int               CNT_BITS     = 16
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_enable,
   input  logic                i_mode,
   input  logic                i_step,
   input  logic                i_stall,
   input  logic                i_halt,
   input  logic                i_jump,
   input  logic [NBITS-1:0]    i_jump_target,
   input  logic                i_branch_taken,
   input  logic [NBITS-1:0]    i_branch_target,
   output logic [NBITS-1:0]    o_pc,
   output logic [NBITS-1:0]    o_pc_plus,
   output logic                o_fetch,
   output logic                o_halted,
   output logic [CNT_BITS-1:0] o_fetch_count
);

   localparam logic [NBITS-1:0] INC_V      = NBITS'(INC);
   // INC is a power of two, so INC-1 covers exactly the bits to clear on target loads.
   localparam logic [NBITS-1:0] ALIGN_MASK = ~(INC_V - NBITS'(1));

   typedef enum logic {RUN, HALTED} state_t;

   state_t              state_q, state_d;
   logic [NBITS-1:0]    pc_q, pc_d;
   logic                fetch_q;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic                step_q;
   logic                adv;
   logic                upd;

   assign o_pc_plus = pc_q + INC_V;

   // Step mode only advances on a rising edge of i_step. Holding i_step high
   // yields a single update.
   assign adv = i_enable & (i_mode ? (i_step & ~step_q) : 1'b1);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      upd     = 1'b0;
      if (state_q == RUN) begin
         if (i_branch_taken) begin
            // The branch is older than any stall or halt, so it wins. A halt
            // decoded behind it is on the wrong path and is dropped.
            if (adv) begin
               pc_d = i_branch_target & ALIGN_MASK;
               upd  = 1'b1;
            end
         end else if (i_halt) begin
            state_d = HALTED;
         end else if (!i_stall) begin
            if (i_jump) begin
               if (adv) begin
                  pc_d = i_jump_target & ALIGN_MASK;
                  upd  = 1'b1;
               end
            end else if (adv) begin
               pc_d = o_pc_plus;
               upd  = 1'b1;
            end
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (upd && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_BITS'(1);
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= RUN;
         pc_q    <= RESET_VECTOR;
         fetch_q <= 1'b0;
         cnt_q   <= '0;
         step_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         fetch_q <= upd;
         cnt_q   <= cnt_d;
         step_q  <= i_step;
      end
   end

   assign o_pc          = pc_q;
   assign o_fetch       = fetch_q;
   assign o_halted      = (state_q == HALTED);
   assign o_fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with two instances.
// Instance a: 32-bit PC, RESET_VECTOR 0x100. Covers run, priority, halt, step and async reset.
// Instance b: 8-bit PC with a 3-bit counter. Covers PC wrap and counter saturation.
module tb_pc_unit;

   logic        clk;
   logic        rst;
   logic        enable, mode, step, stall, halt, jump, branch;
   logic [31:0] jump_tgt, branch_tgt;
   logic [31:0] pc_a, pc_plus_a;
   logic        fetch_a, halted_a;
   logic [15:0] cnt_a;

   logic        enable_b;
   logic        zero_b;
   logic [7:0]  zero8;
   logic [7:0]  pc_b, pc_plus_b;
   logic        fetch_b, halted_b;
   logic [2:0]  cnt_b;

   int tests_run = 0;
   int tests_failed = 0;
   int pulses;

   pc_unit #(.NBITS(32), .INC(4), .RESET_VECTOR(32'h100), .CNT_BITS(16)) u_a (
      .i_clk(clk), .i_reset(rst), .i_enable(enable), .i_mode(mode), .i_step(step),
      .i_stall(stall), .i_halt(halt), .i_jump(jump), .i_jump_target(jump_tgt),
      .i_branch_taken(branch), .i_branch_target(branch_tgt),
      .o_pc(pc_a), .o_pc_plus(pc_plus_a), .o_fetch(fetch_a), .o_halted(halted_a),
      .o_fetch_count(cnt_a)
   );

   pc_unit #(.NBITS(8), .INC(4), .RESET_VECTOR(8'hF0), .CNT_BITS(3)) u_b (
      .i_clk(clk), .i_reset(rst), .i_enable(enable_b), .i_mode(zero_b), .i_step(zero_b),
      .i_stall(zero_b), .i_halt(zero_b), .i_jump(zero_b), .i_jump_target(zero8),
      .i_branch_taken(zero_b), .i_branch_target(zero8),
      .o_pc(pc_b), .o_pc_plus(pc_plus_b), .o_fetch(fetch_b), .o_halted(halted_b),
      .o_fetch_count(cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock edge and settle 1 ns past it before anything is sampled.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctl();
      stall = 0; halt = 0; jump = 0; branch = 0;
   endtask

   initial begin
      rst = 1; enable = 0; mode = 0; step = 0;
      stall = 0; halt = 0; jump = 0; branch = 0;
      jump_tgt = 0; branch_tgt = 0;
      enable_b = 0; zero_b = 0; zero8 = 0;

      // Reset state
      #2;
      check("rst_pc", pc_a, 32'h100);
      check("rst_fetch", {31'd0, fetch_a}, 32'd0);
      check("rst_halted", {31'd0, halted_a}, 32'd0);
      check("rst_cnt", {16'd0, cnt_a}, 32'd0);
      check("rst_pc_plus", pc_plus_a, 32'h104);
      tick();
      rst = 0;
      tick();
      check("idle_pc", pc_a, 32'h100);

      // Continuous run: four updates
      enable = 1;
      tick(); check("run1", pc_a, 32'h104);
      check("run1_fetch", {31'd0, fetch_a}, 32'd1);
      tick(); check("run2", pc_a, 32'h108);
      tick(); check("run3", pc_a, 32'h10C);
      tick(); check("run4", pc_a, 32'h110);
      check("run_cnt", {16'd0, cnt_a}, 32'd4);
      check("run_pc_plus", pc_plus_a, 32'h114);

      // Priority: branch beats jump and stall, and its target is aligned
      jump = 1; jump_tgt = 32'h20;
      tick(); check("jmp_20", pc_a, 32'h20);
      stall = 1; jump = 1; jump_tgt = 32'h80; branch = 1; branch_tgt = 32'h43;
      tick(); check("prio_branch", pc_a, 32'h40);
      clear_ctl(); stall = 1;
      tick(); check("stall_hold", pc_a, 32'h40);
      check("stall_nofetch", {31'd0, fetch_a}, 32'd0);
      check("stall_cnt", {16'd0, cnt_a}, 32'd6);

      // A branch in the same cycle as a halt cancels the halt
      clear_ctl(); halt = 1; branch = 1; branch_tgt = 32'h50;
      tick(); check("hb_pc", pc_a, 32'h50);
      check("hb_halted", {31'd0, halted_a}, 32'd0);

      // Halt, then check that HALTED ignores later requests
      clear_ctl(); jump = 1; jump_tgt = 32'h30;
      tick(); check("jmp_30", pc_a, 32'h30);
      clear_ctl(); halt = 1;
      tick(); check("halt_pc", pc_a, 32'h30);
      check("halt_flag", {31'd0, halted_a}, 32'd1);
      check("halt_nofetch", {31'd0, fetch_a}, 32'd0);
      clear_ctl(); jump = 1; jump_tgt = 32'h90;
      tick(); tick();
      clear_ctl(); mode = 1; step = 1;
      tick(); step = 0; tick(); step = 1; tick();
      check("halted_pc", pc_a, 32'h30);
      check("halted_flag", {31'd0, halted_a}, 32'd1);
      check("halted_nofetch", {31'd0, fetch_a}, 32'd0);

      // Asynchronous reset pulse between edges
      step = 0; mode = 0; enable = 0;
      @(negedge clk);
      rst = 1;
      #1;
      check("arst_pc", pc_a, 32'h100);
      check("arst_halted", {31'd0, halted_a}, 32'd0);
      #1 rst = 0;
      tick();
      check("post_arst_pc", pc_a, 32'h100);

      // Step mode: one update per rising edge of step, however long it is held
      mode = 1; enable = 1; step = 0;
      tick();
      pulses = 0;
      step = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (fetch_a) pulses++;
      end
      check("step_hold_pc", pc_a, 32'h104);
      step = 0;
      tick(); if (fetch_a) pulses++;
      step = 1;
      tick(); if (fetch_a) pulses++;
      check("step_pc", pc_a, 32'h108);
      check("step_pulses", pulses, 32'd2);
      check("step_cnt", {16'd0, cnt_a}, 32'd2);

      // Instance b: wrap from 0xFC to 0x00, and the counter saturates at 7
      step = 0; mode = 0; enable = 0;
      enable_b = 1;
      tick(); tick(); tick();
      check("b_pc_fc", {24'd0, pc_b}, 32'hFC);
      check("b_pc_plus_wrap", {24'd0, pc_plus_b}, 32'h00);
      tick();
      check("b_wrap", {24'd0, pc_b}, 32'h00);
      for (int i = 0; i < 6; i++) tick();
      check("b_pc10", {24'd0, pc_b}, 32'h18);
      check("b_cnt_sat", {29'd0, cnt_b}, 32'd7);
      check("b_halted", {31'd0, halted_b}, 32'd0);
      check("b_fetch", {31'd0, fetch_b}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the pipelined MIPS datapath, successor to the plain PC register. Holds the fetch address, selects the next PC among sequential, jump (ID) and branch (EX) targets, and applies stall, halt and debug single-step control. Sits at the head of the IF stage. It feeds the instruction memory and the IF/ID latch, and reports run state and a fetch counter to the debug unit.

## Interface
- NBITS, 32, PC width in bits
- INC, 4, sequential increment; power of two, 1..2^(NBITS-1)
- RESET_VECTOR, 0, PC value after reset; low log2(INC) bits must be zero
- CNT_BITS, 16, width of fetch counter
- i_clk  in  1  clock, rising edge active
- i_reset  in  1  asynchronous, active-high reset
- i_enable  in  1  global run enable from debug unit
- i_mode  in  1  0 = continuous, 1 = single-step
- i_step  in  1  step request level from debug unit; used in step mode only
- i_stall  in  1  load-use stall from hazard unit
- i_halt  in  1  HALT instruction decoded in ID
- i_jump  in  1  jump resolved in ID
- i_jump_target  in  NBITS  jump destination
- i_branch_taken  in  1  branch resolved taken in EX
- i_branch_target  in  NBITS  branch destination
- o_pc  out  NBITS  current fetch address, registered
- o_pc_plus  out  NBITS  o_pc + INC, combinational, modulo 2^NBITS
- o_fetch  out  1  registered; 1 for the cycle after any PC update
- o_halted  out  1  1 while in HALTED
- o_fetch_count  out  CNT_BITS  number of PC updates since reset, saturating

## Operation
- States: RUN, HALTED. Reset enters RUN.
- Advance permission `adv`:
  - mode 0: i_enable.
  - mode 1: i_enable AND rising edge of i_step. The edge is detected against an internal registered copy of i_step, which resets to 0.
- Next-PC priority in RUN, highest first:
  1. i_branch_taken: load i_branch_target. The branch is older than the stall and the halt, so it overrides i_stall and cancels a same-cycle i_halt. Requires adv.
  2. i_halt (without branch): go to HALTED; PC holds its current value and does not roll back.
  3. i_stall: hold PC.
  4. i_jump: load i_jump_target. Requires adv.
  5. Otherwise load o_pc_plus. Requires adv.
- Without adv, PC holds. In step mode a branch or jump waiting on a step is lost unless the pipeline re-presents it; the pipeline freezes on the same adv, so it does.
- Target loads clear the low log2(INC) bits of the target (forced alignment).
- HALTED is absorbing. PC frozen, o_fetch = 0, all inputs ignored. Exit only by reset.
- Sequential wrap: the PC at 2^NBITS − INC advances to 0 with no flag.
- o_fetch_count increments on each PC update, including a target load equal to the current PC. It sticks at 2^CNT_BITS − 1.
- Step mode: at most one update per i_step rising edge, however long i_step is held high. Switching i_mode mid-run takes effect on the next edge with no state loss.

## Timing
- Reset (async assert, synchronous-edge release): o_pc = RESET_VECTOR, o_fetch = 0, o_halted = 0, o_fetch_count = 0, step edge register = 0, state RUN.
- Reset asserted mid-operation overrides everything immediately, including HALTED and a pending step.
- PC update latency: 1 cycle. Inputs are sampled at edge N; the new o_pc is visible after edge N.
- o_fetch is high during the cycle following an update edge.
- o_halted rises after the edge that samples i_halt.
- o_pc_plus follows o_pc combinationally, with zero latency.

## Test plan
- Reset and run: RESET_VECTOR = 0x100, mode 0, enable = 1 for 4 cycles -> o_pc 0x100, 0x104, 0x108, 0x10C, 0x110; o_fetch_count = 4.
- Priority: at o_pc = 0x20, assert i_stall, i_jump (target 0x80) and i_branch_taken (target 0x43) in the same cycle -> o_pc = 0x40 (branch, aligned). Next cycle stall only -> o_pc stays 0x40.
- Halt: at o_pc = 0x30 assert i_halt for 1 cycle -> o_pc stays 0x30 and o_halted = 1 permanently. Further jumps and steps are ignored. i_halt together with i_branch_taken (target 0x50) -> o_pc = 0x50, o_halted = 0.
- Step mode: mode 1, i_step held high for 5 cycles, then low, then high again -> exactly 2 increments, o_fetch pulses twice.
- Wrap and saturation: NBITS = 8, INC = 4, o_pc = 0xFC -> next 0x00. With CNT_BITS = 3 and 10 updates -> o_fetch_count = 7.
- Async reset while HALTED: pulse i_reset between clock edges -> o_pc = RESET_VECTOR and o_halted = 0 before the next edge.
